// File: rtl/t06_move_sequencer.sv
// Snake-game move sequencer: turns tick pulses into checked head moves, decides
// wall/body/apple outcomes and issues move/grow/clear strobes to the body store.
module t06_move_sequencer #(
    parameter int MAX_LENGTH = 30
) (
    input  logic       system_clk,
    input  logic       nreset,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic [1:0] dir_in,
    input  logic [3:0] head_x,
    input  logic [3:0] head_y,
    input  logic [3:0] apple_x,
    input  logic [3:0] apple_y,
    input  logic       body_hit,
    output logic [3:0] query_x,
    output logic [3:0] query_y,
    output logic [1:0] direction,
    output logic       move_stb,
    output logic       grow_stb,
    output logic       clear_stb,
    output logic [2:0] state,
    output logic [7:0] score,
    output logic       game_over,
    output logic       win
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_CHECK  = 3'd2,
        S_UPDATE = 3'd3,
        S_PAUSED = 3'd4,
        S_DEAD   = 3'd5,
        S_WON    = 3'd6
    } state_t;

    localparam int               LEN_W   = $clog2(MAX_LENGTH + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LENGTH);

    state_t           state_q;
    logic [LEN_W-1:0] length;
    logic             wall_q;

    logic [1:0] next_dir;
    logic [3:0] next_x;
    logic [3:0] next_y;
    logic       next_wall;

    // Candidate step: a 180-degree reversal keeps the current heading, and a
    // step off the board saturates at the edge while flagging a wall hit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next_dir  = (dir_in == {direction[1], ~direction[0]}) ? direction : dir_in;
        next_x    = head_x;
        next_y    = head_y;
        next_wall = 1'b0;
        case (next_dir)
            2'b00: if (head_y == 4'd0)  next_wall = 1'b1; else next_y = head_y - 4'd1;
            2'b01: if (head_y == 4'd15) next_wall = 1'b1; else next_y = head_y + 4'd1;
            2'b10: if (head_x == 4'd0)  next_wall = 1'b1; else next_x = head_x - 4'd1;
            default: if (head_x == 4'd15) next_wall = 1'b1; else next_x = head_x + 4'd1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge system_clk) begin
        if (!nreset) begin
            state_q   <= S_IDLE;
            direction <= 2'b11;
            query_x   <= 4'd0;
            query_y   <= 4'd0;
            score     <= 8'd0;
            length    <= LEN_W'(1);
            wall_q    <= 1'b0;
            move_stb  <= 1'b0;
            grow_stb  <= 1'b0;
            clear_stb <= 1'b0;
            game_over <= 1'b0;
            win       <= 1'b0;
        end else begin
            // Strobes default low so each one lasts exactly one cycle.
            move_stb  <= 1'b0;
            grow_stb  <= 1'b0;
            clear_stb <= 1'b0;
            case (state_q)
                S_IDLE, S_DEAD, S_WON: begin
                    if (start) begin
                        clear_stb <= 1'b1;
                        score     <= 8'd0;
                        length    <= LEN_W'(1);
                        direction <= 2'b11;
                        game_over <= 1'b0;
                        win       <= 1'b0;
                        state_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (pause) begin
                        state_q <= S_PAUSED;
                    end else if (tick) begin
                        direction <= next_dir;
                        query_x   <= next_x;
                        query_y   <= next_y;
                        wall_q    <= next_wall;
                        state_q   <= S_CHECK;
                    end
                end
                S_PAUSED: begin
                    if (!pause) state_q <= S_RUN;
                end
                S_CHECK: begin
                    if (wall_q || body_hit) begin
                        game_over <= 1'b1;
                        state_q   <= S_DEAD;
                    end else if (query_x == apple_x && query_y == apple_y) begin
                        grow_stb <= 1'b1;
                        score    <= score + 8'd1;
                        length   <= length + LEN_W'(1);
                        state_q  <= S_UPDATE;
                    end else begin
                        move_stb <= 1'b1;
                        state_q  <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    // grow_stb is still high here only when this update was a growth.
                    if (grow_stb && length == LEN_MAX) begin
                        win     <= 1'b1;
                        state_q <= S_WON;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state = state_q;

endmodule
